// File: rtl/hex_text_pkg.sv
// hex_text_pkg: FSM encoding, character cell height and the 8x8 hex font shared by the text engine.
package hex_text_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DIGIT, WRITE, ADVANCE} state_e;

  localparam int CELL_H = 10;

  // Glyph rows 0..7 land on cell lines 1..8; bit 7 is the leftmost pixel.
  localparam logic [7:0] GLYPH_TAB [16][8] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00},
    '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00},
    '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},
    '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
    '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},
    '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00},
    '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00}
  };
endpackage

// File: rtl/hex_glyph_rom.sv
// hex_glyph_rom: combinational lookup of one 8-pixel glyph row for a hex digit.
module hex_glyph_rom
  import hex_text_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] line,
  output logic [7:0] row
);
  assign row = GLYPH_TAB[digit][line];
endmodule

// File: rtl/hex_text_engine.sv
// hex_text_engine: fetches words per (row, field) and renders them as hex text cells into a frame buffer.
// Build option HEX_LZ_BLANK_EN renders leading zero digits of a field as blank cells.
module hex_text_engine
  import hex_text_pkg::*;
#(
  parameter int NUM_ROWS    = 32,
  parameter int NUM_FIELDS  = 6,
  parameter int DATA_W      = 32,
  parameter int SCREEN_COLS = 80,
  parameter int ADDR_W      = 16,
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int FLD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
)(
  input  logic                    clock25,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_FIELDS*7-1:0] field_col,
  input  logic [NUM_FIELDS*4-1:0] field_digits,
  output logic                    src_req,
  input  logic                    src_ack,
  output logic [ROW_W-1:0]        src_row,
  output logic [FLD_W-1:0]        src_field,
  input  logic [DATA_W-1:0]       src_data,
  output logic                    fb_we,
  input  logic                    fb_ready,
  output logic [ADDR_W-1:0]       fb_addr,
  output logic [7:0]              fb_data,
  output logic                    busy,
  output logic                    done
);
  localparam int MAX_DIG = DATA_W / 4;
  localparam int DIG_W   = $clog2(MAX_DIG + 1);
  localparam int RW1     = ROW_W + 1;

  state_e             state_q, state_d;
  logic [RW1-1:0]     row_q, row_d, nxt_row;   // one extra bit so row == NUM_ROWS marks pass end
  logic [FLD_W-1:0]   fld_q, fld_d, nxt_fld;
  logic [DIG_W-1:0]   dig_q, dig_d, ndig_q, ndig_d, cur_cnt;
  logic [3:0]         line_q, line_d, nib_q, nib_d, cnt_raw, nib_c;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [31:0]        col_q, col_d, col_c, nsel;
  logic               blank_q, blank_d, lz_q, lz_d, lead_c, done_q, done_d;
  logic [7:0]         glyph;

  hex_glyph_rom u_rom (.digit(nib_q), .line(3'(line_q - 4'd1)), .row(glyph));

  always_comb begin
    state_d = state_q; row_d = row_q; fld_d = fld_q; dig_d = dig_q; ndig_d = ndig_q;
    line_d = line_q; word_d = word_q; nib_d = nib_q; blank_d = blank_q; lz_d = lz_q;
    col_d = col_q; done_d = 1'b0;
    cnt_raw = field_digits[fld_q*4 +: 4];
    cur_cnt = (32'(cnt_raw) > MAX_DIG) ? DIG_W'(MAX_DIG) : DIG_W'(cnt_raw);
    if (fld_q == FLD_W'(NUM_FIELDS - 1)) begin
      nxt_fld = '0;
      nxt_row = row_q + RW1'(1);
    end else begin
      nxt_fld = fld_q + FLD_W'(1);
      nxt_row = row_q;
    end
    col_c  = 32'(field_col[fld_q*7 +: 7]) + 32'(dig_q);
    nsel   = 32'(ndig_q) - 32'(dig_q) - 32'd1;
    nib_c  = word_q[nsel*4 +: 4];
    lead_c = lz_q && (nib_c == 4'd0) && (dig_q != ndig_q - DIG_W'(1));
    unique case (state_q)
      IDLE: if (start) begin
        // pointer already sits at (0,0) here, so field 0 can be fetched without an extra cycle
        if (cur_cnt != '0) begin
          state_d = FETCH; ndig_d = cur_cnt; dig_d = '0; lz_d = 1'b1;
        end else begin
          state_d = ADVANCE; row_d = nxt_row; fld_d = nxt_fld;
        end
      end
      ADVANCE: begin
        if (row_q == RW1'(NUM_ROWS)) begin
          state_d = IDLE; row_d = '0; fld_d = '0; done_d = 1'b1;
        end else if (cur_cnt == '0) begin
          row_d = nxt_row; fld_d = nxt_fld;
        end else begin
          state_d = FETCH; ndig_d = cur_cnt; dig_d = '0; lz_d = 1'b1;
        end
      end
      FETCH: if (src_ack) begin
        word_d = src_data; state_d = DIGIT;
      end
      DIGIT: begin
        if (col_c >= 32'(SCREEN_COLS)) begin
          state_d = ADVANCE; row_d = nxt_row; fld_d = nxt_fld;
        end else begin
          state_d = WRITE; nib_d = nib_c; line_d = '0; col_d = col_c; lz_d = lead_c;
`ifdef HEX_LZ_BLANK_EN
          blank_d = lead_c;
`else
          blank_d = 1'b0;
`endif
        end
      end
      WRITE: if (fb_ready) begin
        if (line_q == 4'(CELL_H - 1)) begin
          if (dig_q == ndig_q - DIG_W'(1)) begin
            state_d = ADVANCE; row_d = nxt_row; fld_d = nxt_fld;
          end else begin
            state_d = DIGIT; dig_d = dig_q + DIG_W'(1);
          end
        end else begin
          line_d = line_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; row_q <= '0; fld_q <= '0; dig_q <= '0; ndig_q <= '0;
      line_q <= '0; word_q <= '0; nib_q <= '0; blank_q <= 1'b0; lz_q <= 1'b0;
      col_q <= '0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; row_q <= row_d; fld_q <= fld_d; dig_q <= dig_d; ndig_q <= ndig_d;
      line_q <= line_d; word_q <= word_d; nib_q <= nib_d; blank_q <= blank_d; lz_q <= lz_d;
      col_q <= col_d; done_q <= done_d;
    end
  end

  assign src_req   = (state_q == FETCH);
  assign src_row   = row_q[ROW_W-1:0];
  assign src_field = fld_q;
  assign fb_we     = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign fb_addr   = fb_we ? ADDR_W'((32'(row_q) * 32'(CELL_H) + 32'(line_q)) * 32'(SCREEN_COLS) + col_q)
                           : '0;

  // top and bottom cell lines are spacing; blanked digits keep their writes but carry no pixels
  always_comb begin
    fb_data = 8'h00;
    if (fb_we && line_q != 4'd0 && line_q != 4'(CELL_H - 1) && !blank_q) fb_data = glyph;
  end
endmodule

// File: tb/tb_hex_text_engine.sv
// tb_hex_text_engine: randomized source/sink agents with a pass-level reference model of the rendered text.
module tb_hex_text_engine;
  localparam int NR = 4, NF = 3, COLS = 80;
`ifdef HEX_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam logic [7:0] FONT [16][8] = '{
    '{8'h3C,8'h66,8'h6E,8'h76,8'h66,8'h66,8'h3C,8'h00}, '{8'h18,8'h38,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00},
    '{8'h3C,8'h66,8'h06,8'h0C,8'h30,8'h60,8'h7E,8'h00}, '{8'h3C,8'h66,8'h06,8'h1C,8'h06,8'h66,8'h3C,8'h00},
    '{8'h0C,8'h1C,8'h3C,8'h6C,8'h7E,8'h0C,8'h0C,8'h00}, '{8'h7E,8'h60,8'h7C,8'h06,8'h06,8'h66,8'h3C,8'h00},
    '{8'h3C,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h3C,8'h00}, '{8'h7E,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h00},
    '{8'h3C,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h3C,8'h00}, '{8'h3C,8'h66,8'h66,8'h3E,8'h06,8'h0C,8'h38,8'h00},
    '{8'h18,8'h3C,8'h66,8'h66,8'h7E,8'h66,8'h66,8'h00}, '{8'h7C,8'h66,8'h66,8'h7C,8'h66,8'h66,8'h7C,8'h00},
    '{8'h3C,8'h66,8'h60,8'h60,8'h60,8'h66,8'h3C,8'h00}, '{8'h78,8'h6C,8'h66,8'h66,8'h66,8'h6C,8'h78,8'h00},
    '{8'h7E,8'h60,8'h60,8'h7C,8'h60,8'h60,8'h7E,8'h00}, '{8'h7E,8'h60,8'h60,8'h7C,8'h60,8'h60,8'h60,8'h00}};

  logic clock25 = 1'b0, rst_n, start, src_req, src_ack, fb_we, fb_ready, busy, done;
  logic [NF*7-1:0] field_col;
  logic [NF*4-1:0] field_digits;
  logic [1:0] src_row, src_field;
  logic [31:0] src_data;
  logic [15:0] fb_addr;
  logic [7:0] fb_data;

  hex_text_engine #(.NUM_ROWS(NR), .NUM_FIELDS(NF), .DATA_W(32), .SCREEN_COLS(COLS), .ADDR_W(16)) dut (
    .clock25(clock25), .rst_n(rst_n), .start(start), .field_col(field_col), .field_digits(field_digits),
    .src_req(src_req), .src_ack(src_ack), .src_row(src_row), .src_field(src_field), .src_data(src_data),
    .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .done(done));

  always #5 clock25 = ~clock25;

  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] mem [NR][NF];
  int ack_delay = 0, rdy_mode = 0, stall_left = 0, hold_cnt = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  bit stall_arm = 0;
  logic [23:0] wq[$], exp_w[$];
  logic [3:0] fq[$], exp_f[$];

  always @(posedge clock25) cyc++;

  // source agent: delays ack, drives junk data except on the ack cycle
  initial begin
    int wait_cnt; bit holding, acked_prev; logic [1:0] hr, hf;
    src_ack = 0; src_data = '0; holding = 0; acked_prev = 0; wait_cnt = 0; hr = 0; hf = 0;
    forever begin
      @(posedge clock25); #1;
      if (acked_prev) begin
        checks++;
        if (src_req !== 1'b0) begin errors++; $display("FAIL src_drop: src_req=%b required 0", src_req); end
      end
      src_ack = 0; src_data = $urandom;
      if (rst_n && src_req) begin
        if (!holding) begin
          holding = 1; hr = src_row; hf = src_field; wait_cnt = 0; fq.push_back({src_row, src_field});
        end else begin
          checks++;
          if (src_row !== hr || src_field !== hf) begin
            errors++; $display("FAIL src_hold: row/field %0d/%0d required %0d/%0d", src_row, src_field, hr, hf);
          end
        end
        if (wait_cnt >= ack_delay) begin src_ack = 1; src_data = mem[src_row][src_field]; end
        wait_cnt++;
      end else holding = 0;
      acked_prev = src_ack;
    end
  end

  // sink ready driver
  initial begin
    fb_ready = 1;
    forever begin
      @(posedge clock25); #1;
      if (stall_arm && fb_we && wq.size() == 13) begin stall_left = 5; stall_arm = 0; end
      if (rdy_mode == 1) fb_ready = ($urandom_range(0, 3) != 0);
      else if (stall_left > 0) begin fb_ready = 0; stall_left--; end
      else fb_ready = 1;
    end
  end

  // sink monitor: captures accepted writes, checks hold while stalled, counts done pulses
  initial begin
    bit pend; logic [15:0] pa; logic [7:0] pd;
    pend = 0; pa = 0; pd = 0;
    forever begin
      @(negedge clock25);
      if (!rst_n) pend = 0;
      else begin
        if (pend) begin
          checks++; hold_cnt++;
          if (fb_we !== 1'b1 || fb_addr !== pa || fb_data !== pd) begin
            errors++; $display("FAIL fb_hold: we=%b addr=%h data=%h required we=1 addr=%h data=%h", fb_we, fb_addr, fb_data, pa, pd);
          end
        end
        pend = fb_we && !fb_ready; pa = fb_addr; pd = fb_data;
        if (fb_we && fb_ready) begin wq.push_back({fb_addr, fb_data}); last_wr_cyc = cyc; end
        if (done) begin
          done_cnt++; done_cyc = cyc; checks++;
          if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: busy=%b required 0", busy); end
        end
      end
    end
  end

  task automatic set_field(input int f, input int col, input int dig);
    field_col[f*7 +: 7] = 7'(col); field_digits[f*4 +: 4] = 4'(dig);
  endtask

  task automatic fill_mem(input bit rnd, input logic [31:0] val);
    for (int r = 0; r < NR; r++) for (int f = 0; f < NF; f++) mem[r][f] = rnd ? $urandom : val;
  endtask

  task automatic build_model();
    exp_w.delete(); exp_f.delete();
    for (int r = 0; r < NR; r++) for (int f = 0; f < NF; f++) begin
      int n, col, nib; bit lead; logic [7:0] px;
      n = int'(field_digits[f*4 +: 4]); if (n > 8) n = 8;
      if (n == 0) continue;
      exp_f.push_back({2'(r), 2'(f)});
      lead = 1;
      for (int d = 0; d < n; d++) begin
        col = int'(field_col[f*7 +: 7]) + d;
        if (col >= COLS) break;
        nib = int'((mem[r][f] >> (4 * (n - 1 - d))) & 32'hF);
        lead = lead && (nib == 0) && (d != n - 1);
        for (int l = 0; l < 10; l++) begin
          px = 8'h00;
          if (l != 0 && l != 9 && !(LZ && lead)) px = FONT[nib][l-1];
          exp_w.push_back({16'((r * 10 + l) * COLS + col), px});
        end
      end
    end
  endtask

  task automatic run_pass(input bit poke, output bit b1, output bit r1);
    int t;
    wq.delete(); fq.delete(); done_cnt = 0;
    @(posedge clock25); #1; start = 1;
    @(posedge clock25); #1; start = 0; b1 = busy; r1 = src_req;
    t = 0;
    while (done_cnt == 0 && t < 20000) begin
      @(posedge clock25); #1; start = poke && (t == 50); t++;
    end
    start = 0;
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL pass_timeout: no done after %0d cycles required done", t); end
    repeat (4) @(posedge clock25);
  endtask

  task automatic check_pass(input string name);
    int bad;
    build_model();
    checks++;
    if (wq.size() != exp_w.size()) begin
      errors++; $display("FAIL %s_count: %0d writes required %0d", name, wq.size(), exp_w.size());
    end
    bad = -1;
    for (int i = 0; i < wq.size() && i < exp_w.size(); i++) if (wq[i] !== exp_w[i]) begin bad = i; break; end
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL %s_write: write %0d addr/data %h required %h", name, bad, wq[bad], exp_w[bad]);
    end
    checks++;
    if (fq != exp_f) begin errors++; $display("FAIL %s_fetch: %0d fetches required %0d in order", name, fq.size(), exp_f.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s_done: %0d done pulses required 1", name, done_cnt); end
    if (wq.size() > 0) begin
      checks++;
      if (done_cyc <= last_wr_cyc) begin errors++; $display("FAIL %s_done_order: done at %0d last write %0d", name, done_cyc, last_wr_cyc); end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; field_col = '0; field_digits = '0; fill_mem(1, 0);
    repeat (3) @(posedge clock25); #1;
    checks++;
    if ({src_req, fb_we, busy, done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctl: req/we/busy/done=%b required 0000", {src_req, fb_we, busy, done});
    end
    checks++;
    if ({src_row, src_field, fb_addr, fb_data} !== 28'h0) begin
      errors++; $display("FAIL reset_data: row/field/addr/data=%h required 0", {src_row, src_field, fb_addr, fb_data});
    end
    rst_n = 1; repeat (2) @(posedge clock25);
  endtask

  task automatic test_basic();
    bit b1, r1; int n0;
    set_field(0, 0, 8); set_field(1, 0, 0); set_field(2, 0, 0); fill_mem(0, 32'h0123ABCF);
    ack_delay = 0; rdy_mode = 0;
    run_pass(0, b1, r1);
    checks++;
    if (!(b1 === 1'b1 && r1 === 1'b1)) begin errors++; $display("FAIL start_resp: busy=%b req=%b required 1 1", b1, r1); end
    n0 = 0; foreach (wq[i]) if (wq[i][23:8] < 16'd800) n0++;
    checks++;
    if (n0 != 80) begin errors++; $display("FAIL basic_row0: %0d writes required 80", n0); end
    checks++;
    if (wq.size() < 2 || wq[0] !== 24'h0000_00 || wq[1] !== {16'd80, 8'h3C}) begin
      errors++; $display("FAIL basic_first: first two writes %h %h required 000000 00503c", wq.size() > 0 ? wq[0] : 24'h0, wq.size() > 1 ? wq[1] : 24'h0);
    end
    check_pass("basic");
  endtask

  task automatic test_ack_delay();
    bit b1, r1;
    set_field(0, 0, 4); set_field(1, 10, 3); set_field(2, 30, 0); fill_mem(1, 0);
    ack_delay = 7; rdy_mode = 0;
    run_pass(0, b1, r1);
    check_pass("ack_delay");
    ack_delay = 0;
  endtask

  task automatic test_stall();
    bit b1, r1;
    set_field(0, 5, 3); set_field(1, 20, 2); set_field(2, 0, 0); fill_mem(1, 0);
    rdy_mode = 2; stall_arm = 1; hold_cnt = 0;
    run_pass(0, b1, r1);
    checks++;
    if (hold_cnt < 5) begin errors++; $display("FAIL stall_seen: %0d held cycles required at least 5", hold_cnt); end
    check_pass("stall");
    rdy_mode = 0; stall_arm = 0;
  endtask

  task automatic test_clip();
    bit b1, r1; bit ok;
    set_field(0, 78, 4); set_field(1, 0, 0); set_field(2, 0, 0); fill_mem(1, 0);
    run_pass(0, b1, r1);
    ok = 1; foreach (wq[i]) if (wq[i][23:8] % COLS < 78) ok = 0;
    checks++;
    if (wq.size() != NR * 20 || !ok) begin errors++; $display("FAIL clip: %0d writes cols_ok=%b required %0d cols_ok=1", wq.size(), ok, NR * 20); end
    check_pass("clip");
  endtask

  task automatic test_lz();
    bit b1, r1; logic [7:0] e0;
    set_field(0, 0, 8); set_field(1, 0, 0); set_field(2, 0, 0); fill_mem(0, 32'h0000001F);
    run_pass(0, b1, r1);
    e0 = LZ ? 8'h00 : 8'h3C;
    checks++;
    if (wq.size() < 80 || wq[1][7:0] !== e0 || wq[61][7:0] !== 8'h18 || wq[71][7:0] !== 8'h7E) begin
      errors++; $display("FAIL lz_cells: cell0/6/7 line1 %h %h %h required %h 18 7e",
        wq.size() > 1 ? wq[1][7:0] : 8'h0, wq.size() > 61 ? wq[61][7:0] : 8'h0, wq.size() > 71 ? wq[71][7:0] : 8'h0, e0);
    end
    check_pass("lz");
  endtask

  task automatic test_mid_reset();
    bit b1, r1; int t;
    set_field(0, 0, 2); set_field(1, 0, 0); set_field(2, 0, 0); fill_mem(1, 0);
    @(posedge clock25); #1; start = 1;
    @(posedge clock25); #1; start = 0;
    t = 0;
    while (!(fb_we && src_row == 2'd3) && t < 5000) begin @(posedge clock25); #1; t++; end
    checks++;
    if (t >= 5000) begin errors++; $display("FAIL mid_reset_reach: row 3 write not seen in %0d cycles", t); end
    repeat (2) @(posedge clock25); #1;
    rst_n = 0; done_cnt = 0; #1;
    checks++;
    if ({src_req, fb_we, busy, done, src_row, src_field, fb_addr, fb_data} !== 32'h0) begin
      errors++; $display("FAIL mid_reset_outs: %h required 0", {src_req, fb_we, busy, done, src_row, src_field, fb_addr, fb_data});
    end
    repeat (3) @(posedge clock25); #1;
    rst_n = 1;
    repeat (5) @(posedge clock25); #1;
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: done=%0d busy=%b required 0 0", done_cnt, busy); end
    run_pass(0, b1, r1);
    check_pass("restart");
  endtask

  task automatic test_random();
    bit b1, r1;
    for (int p = 0; p < 5; p++) begin
      for (int f = 0; f < NF; f++) set_field(f, $urandom_range(0, 90), $urandom_range(0, 12));
      fill_mem(1, 0);
      ack_delay = $urandom_range(0, 3); rdy_mode = 1;
      run_pass(p[0], b1, r1);
      check_pass("random");
    end
    rdy_mode = 0; ack_delay = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_stall();
    test_clip();
    test_lz();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
